// File: rtl/state_dump_unit.sv
// End-of-run state readout: halts the core, then streams every register-file
// entry followed by every data-memory word over a valid/ready channel.
module state_dump_unit #(
   parameter  int CPU_DATA_WIDTH              = 32,
   parameter  int REGISTER_FILE_ADDRESS_WIDTH = 5,
   parameter  int DATA_ADDRESS_WIDTH          = 6,
   localparam int IDX_W = (REGISTER_FILE_ADDRESS_WIDTH > DATA_ADDRESS_WIDTH) ?
                          REGISTER_FILE_ADDRESS_WIDTH : DATA_ADDRESS_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start_i,
   input  logic                                   abort_i,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   halt_req_o,
   input  logic                                   halt_ack_i,
   output logic                                   rf_rd_en_o,
   output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] rf_addr_o,
   input  logic [CPU_DATA_WIDTH-1:0]              rf_data_i,
   output logic                                   dm_rd_en_o,
   output logic [DATA_ADDRESS_WIDTH-1:0]          dm_addr_o,
   input  logic [CPU_DATA_WIDTH-1:0]              dm_data_i,
   output logic                                   out_valid_o,
   input  logic                                   out_ready_i,
   output logic [CPU_DATA_WIDTH-1:0]              out_data_o,
   output logic                                   out_is_mem_o,
   output logic [IDX_W-1:0]                       out_index_o,
   output logic                                   out_last_o
);

   localparam logic [IDX_W-1:0] RF_LAST = IDX_W'((1 << REGISTER_FILE_ADDRESS_WIDTH) - 1);
   localparam logic [IDX_W-1:0] DM_LAST = IDX_W'((1 << DATA_ADDRESS_WIDTH) - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT, S_READ, S_LATCH, S_SEND, S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      src_mem_q, src_mem_d;
   logic [CPU_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                      out_is_mem_q, out_is_mem_d;
   logic [IDX_W-1:0]          out_index_q, out_index_d;
   logic                      out_last_q, out_last_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         src_mem_q    <= 1'b0;
         out_data_q   <= '0;
         out_is_mem_q <= 1'b0;
         out_index_q  <= '0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         src_mem_q    <= src_mem_d;
         out_data_q   <= out_data_d;
         out_is_mem_q <= out_is_mem_d;
         out_index_q  <= out_index_d;
         out_last_q   <= out_last_d;
      end
   end

   // Abort wins over every other transition once a dump is underway.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_HALT;
         S_HALT:  if (abort_i) state_d = S_IDLE;
                  else if (halt_ack_i) state_d = S_READ;
         S_READ:  state_d = abort_i ? S_IDLE : S_LATCH;
         S_LATCH: state_d = abort_i ? S_IDLE : S_SEND;
         S_SEND:  if (abort_i) state_d = S_IDLE;
                  else if (out_ready_i) state_d = out_last_q ? S_DONE : S_READ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d        = idx_q;
      src_mem_d    = src_mem_q;
      out_data_d   = out_data_q;
      out_is_mem_d = out_is_mem_q;
      out_index_d  = out_index_q;
      out_last_d   = out_last_q;
      if (state_q == S_HALT && halt_ack_i) begin
         idx_d     = '0;
         src_mem_d = 1'b0;
      end
      if (state_q == S_LATCH) begin
         out_data_d   = src_mem_q ? dm_data_i : rf_data_i;
         out_is_mem_d = src_mem_q;
         out_index_d  = idx_q;
         out_last_d   = src_mem_q && (idx_q == DM_LAST);
      end
      // Register index wraps into the memory region rather than back to x0.
      if (state_q == S_SEND && out_ready_i && !out_last_q) begin
         if (!src_mem_q && idx_q == RF_LAST) begin
            idx_d     = '0;
            src_mem_d = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_comb begin
      busy_o       = (state_q != S_IDLE);
      halt_req_o   = (state_q != S_IDLE);
      done_o       = (state_q == S_DONE);
      out_valid_o  = (state_q == S_SEND);
      rf_rd_en_o   = (state_q == S_READ) && !src_mem_q;
      dm_rd_en_o   = (state_q == S_READ) && src_mem_q;
      rf_addr_o    = rf_rd_en_o ? idx_q[REGISTER_FILE_ADDRESS_WIDTH-1:0] : '0;
      dm_addr_o    = dm_rd_en_o ? idx_q[DATA_ADDRESS_WIDTH-1:0] : '0;
      out_data_o   = out_data_q;
      out_is_mem_o = out_is_mem_q;
      out_index_o  = out_index_q;
      out_last_o   = out_last_q;
   end

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit: full dumps, backpressure, slow halt ack,
// start-while-busy, abort and asynchronous reset mid-dump.
module tb_state_dump_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0, abort_i = 1'b0, out_ready_i = 1'b1;
   logic        busy_o, done_o, halt_req_o, halt_ack_i;
   logic        rf_rd_en_o, dm_rd_en_o, out_valid_o, out_is_mem_o, out_last_o;
   logic [4:0]  rf_addr_o;
   logic [5:0]  dm_addr_o, out_index_o;
   logic [31:0] rf_data_i = '0, dm_data_i = '0, out_data_o;

   int checks = 0;
   int errors = 0;
   int ack_delay = 0;
   int hcnt = 0;
   logic clr = 1'b0;
   int nb = 0;
   int ndone = 0;
   logic [31:0] bdata [0:255];
   logic        bmem  [0:255];
   logic [5:0]  bidx  [0:255];
   logic        blast [0:255];

   always #5 clk = ~clk;

   state_dump_unit dut (
      .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
      .busy_o(busy_o), .done_o(done_o), .halt_req_o(halt_req_o), .halt_ack_i(halt_ack_i),
      .rf_rd_en_o(rf_rd_en_o), .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i),
      .dm_rd_en_o(dm_rd_en_o), .dm_addr_o(dm_addr_o), .dm_data_i(dm_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_is_mem_o(out_is_mem_o), .out_index_o(out_index_o), .out_last_o(out_last_o)
   );

   // Synchronous-read memories and a core that acks ack_delay cycles after halt_req.
   always @(posedge clk) begin
      if (rf_rd_en_o) rf_data_i <= 32'(rf_addr_o) * 32'd3;
      if (dm_rd_en_o) dm_data_i <= 32'hA500_0000 + 32'(dm_addr_o);
      hcnt <= halt_req_o ? hcnt + 1 : 0;
   end
   assign halt_ack_i = halt_req_o && (hcnt >= ack_delay);

   always @(posedge clk) begin
      if (clr) begin
         nb    <= 0;
         ndone <= 0;
      end else begin
         if (out_valid_o && out_ready_i && nb < 256) begin
            bdata[nb] <= out_data_o;
            bmem[nb]  <= out_is_mem_o;
            bidx[nb]  <= out_index_o;
            blast[nb] <= out_last_o;
            nb        <= nb + 1;
         end
         if (done_o) ndone <= ndone + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_beat(input int k);
      logic [31:0] d;
      logic        m, l;
      logic [5:0]  i;
      if (k < 32) begin
         m = 1'b0; i = 6'(k); d = 32'(3 * k); l = 1'b0;
      end else begin
         m = 1'b1; i = 6'(k - 32); d = 32'hA500_0000 + 32'(k - 32); l = (k == 95);
      end
      return {24'd0, m, i, l, d};
   endfunction

   task automatic verify_beats(input string tag, input int n);
      chk({tag, "_count"}, 64'(nb), 64'(n));
      for (int k = 0; k < n && k < nb; k++)
         chk($sformatf("%s_beat%0d", tag, k),
             {24'd0, bmem[k], bidx[k], blast[k], bdata[k]}, exp_beat(k));
   endtask

   task automatic clear_mon();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
   endtask

   task automatic pulse_start(input string tag);
      @(negedge clk) start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
      chk({tag, "_busy_halt_on_start"}, 64'({busy_o, halt_req_o}), 64'b11);
   endtask

   task automatic wait_beat(input string tag, input logic mem, input int idx);
      int n = 0;
      while (!(out_valid_o && out_is_mem_o == mem && int'(out_index_o) == idx) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_beat_timeout"}, 64'(n < 1000), 64'd1);
   endtask

   task automatic finish_dump(input string tag, output int cyc);
      cyc = 0;
      while (!done_o && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_done_timeout"}, 64'(cyc < 2000), 64'd1);
      @(negedge clk);
      chk({tag, "_idle_after_done"}, 64'({busy_o, halt_req_o, done_o}), 64'd0);
      chk({tag, "_done_pulses"}, 64'(ndone), 64'd1);
      verify_beats(tag, 96);
   endtask

   initial begin
      int cyc, n;
      logic strobes;

      // Reset: all outputs low while rst is held
      #1 rst = 1'b1;
      #2 chk("reset_outs", 64'({busy_o, done_o, halt_req_o, rf_rd_en_o, rf_addr_o, dm_rd_en_o,
                                 dm_addr_o, out_valid_o, out_data_o, out_is_mem_o, out_index_o,
                                 out_last_o}), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("post_reset_idle", 64'({busy_o, rf_rd_en_o, dm_rd_en_o, out_valid_o}), 64'd0);

      // Full dump, immediate ack, ready high: DONE 289 cycles after start
      clear_mon();
      pulse_start("full");
      finish_dump("full", cyc);
      chk("full_cycles", 64'(cyc), 64'd289);

      // Backpressure on beat 10
      clear_mon();
      pulse_start("bp");
      wait_beat("bp", 1'b0, 10);
      out_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", i), 64'({out_valid_o, out_is_mem_o, out_index_o, out_data_o}),
             {25'd0, 1'b1, 1'b0, 6'd10, 32'd30});
      end
      out_ready_i = 1'b1;
      finish_dump("bp", cyc);

      // Slow halt acknowledge: no reads before the ack
      ack_delay = 7;
      clear_mon();
      pulse_start("hd");
      n = 0;
      strobes = 1'b0;
      while (!halt_ack_i && n < 50) begin
         strobes |= rf_rd_en_o | dm_rd_en_o;
         @(negedge clk);
         n++;
      end
      chk("hd_no_reads_before_ack", 64'(strobes), 64'd0);
      chk("hd_ack_delay", 64'(n), 64'd7);
      @(negedge clk);
      chk("hd_first_read", 64'({rf_rd_en_o, dm_rd_en_o, rf_addr_o}), {57'd0, 2'b10, 5'd0});
      finish_dump("hd", cyc);
      ack_delay = 0;

      // Start while busy is ignored; abort at beat 40 withdraws it
      clear_mon();
      pulse_start("ab");
      wait_beat("ab20", 1'b0, 20);
      start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
      wait_beat("ab40", 1'b1, 8);
      out_ready_i = 1'b0;
      abort_i = 1'b1;
      @(negedge clk) abort_i = 1'b0;
      chk("ab_idle", 64'({out_valid_o, halt_req_o, busy_o, done_o}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk("ab_no_done", 64'(ndone), 64'd0);
      verify_beats("ab", 40);
      out_ready_i = 1'b1;
      clear_mon();
      pulse_start("ab_re");
      finish_dump("ab_re", cyc);

      // Asynchronous reset during SEND of beat 50
      clear_mon();
      pulse_start("rs");
      wait_beat("rs", 1'b1, 18);
      out_ready_i = 1'b0;
      #2 rst = 1'b1;
      #1 chk("rs_async_clear", 64'({busy_o, done_o, halt_req_o, rf_rd_en_o, dm_rd_en_o,
                                     out_valid_o, out_data_o, out_is_mem_o, out_index_o,
                                     out_last_o}), 64'd0);
      @(negedge clk) rst = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk);
      chk("rs_idle_no_done", 64'({busy_o, 31'(ndone)}), 64'd0);
      clear_mon();
      pulse_start("rs_re");
      finish_dump("rs_re", cyc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
